// File: rtl/shift_pkg.sv
// Shared constants and types for the shift arbiter and its shifter core.
package shift_pkg;

  localparam int SHIFT_DATA_W  = 32;
  localparam int SHIFT_SHAMT_W = 5;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // The core has no meaning for OP_ILL, so it is steered to a harmless SLL.
  function automatic logic [1:0] core_type(input logic [1:0] op);
    return (op == OP_ILL) ? OP_SLL : op;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request, response and grant-counter signals between two requesters, a consumer and the arbiter.
interface shift_arbiter_if
  import shift_pkg::*;
#(
  parameter int DATA_W  = SHIFT_DATA_W,
  parameter int SHAMT_W = SHIFT_SHAMT_W,
  parameter int CNT_W   = 16
);

  logic               req0_valid;
  logic               req0_ready;
  logic [DATA_W-1:0]  req0_a;
  logic [SHAMT_W-1:0] req0_shamt;
  logic [1:0]         req0_op;

  logic               req1_valid;
  logic               req1_ready;
  logic [DATA_W-1:0]  req1_a;
  logic [SHAMT_W-1:0] req1_shamt;
  logic [1:0]         req1_op;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_err;

  logic [CNT_W-1:0]   gnt0_cnt;
  logic [CNT_W-1:0]   gnt1_cnt;

  modport master (
    output req0_valid, req0_a, req0_shamt, req0_op,
    output req1_valid, req1_a, req1_shamt, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    input  gnt0_cnt, gnt1_cnt
  );

  modport slave (
    input  req0_valid, req0_a, req0_shamt, req0_op,
    input  req1_valid, req1_a, req1_shamt, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    output gnt0_cnt, gnt1_cnt
  );

endinterface

// File: rtl/Shift1.sv
// Combinational barrel shifter core: SRL/SLL zero-fill, SRA sign-fill; any other type passes a through.
module Shift1
  import shift_pkg::*;
#(
  parameter int W  = SHIFT_DATA_W,
  parameter int SW = SHIFT_SHAMT_W
) (
  input  logic [W-1:0]  a,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    op_type,
  output logic [W-1:0]  r
);

  always_comb begin
    r = a;
    case (op_type)
      OP_SRL:  r = a >> shamt;
      OP_SLL:  r = a << shamt;
      OP_SRA:  r = $signed(a) >>> shamt;
      default: r = a;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one shifter between two requesters, with a single registered response stage.
// Results appear one cycle after accept; a stalled response blocks both requesters.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int DATA_W  = SHIFT_DATA_W,
  parameter int SHAMT_W = SHIFT_SHAMT_W,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave sa_if
);

  state_t             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   gnt0_cnt_q, gnt0_cnt_d;
  logic [CNT_W-1:0]   gnt1_cnt_q, gnt1_cnt_d;

  logic               both_vld;
  logic               any_vld;
  logic               win_id;
  logic               can_accept;
  logic               accept;
  logic [DATA_W-1:0]  sel_a;
  logic [SHAMT_W-1:0] sel_shamt;
  logic [1:0]         sel_op;
  logic [SHAMT_W-1:0] core_shamt;
  logic [1:0]         core_op;
  logic [DATA_W-1:0]  core_r;

  // Arbitration and operand steering
  always_comb begin
    both_vld   = sa_if.req0_valid & sa_if.req1_valid;
    any_vld    = sa_if.req0_valid | sa_if.req1_valid;
    win_id     = both_vld ? rr_ptr_q : sa_if.req1_valid;
    can_accept = (state_q == ST_EMPTY) | sa_if.rsp_ready;
    accept     = any_vld & can_accept & ~rst;

    sel_a      = win_id ? sa_if.req1_a     : sa_if.req0_a;
    sel_shamt  = win_id ? sa_if.req1_shamt : sa_if.req0_shamt;
    sel_op     = win_id ? sa_if.req1_op    : sa_if.req0_op;

    core_op    = core_type(sel_op);
    core_shamt = (sel_op == OP_ILL) ? '0 : sel_shamt;
  end

  assign sa_if.req0_ready = accept & ~win_id;
  assign sa_if.req1_ready = accept &  win_id;

  Shift1 #(
    .W  (DATA_W),
    .SW (SHAMT_W)
  ) u_shift (
    .a       (sel_a),
    .shamt   (core_shamt),
    .op_type (core_op),
    .r       (core_r)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    gnt0_cnt_d = gnt0_cnt_q;
    gnt1_cnt_d = gnt1_cnt_q;

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && sa_if.rsp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (accept) begin
      rsp_id_d   = win_id;
      rsp_data_d = core_r;
      rsp_err_d  = (sel_op == OP_ILL);
      if (both_vld) rr_ptr_d = ~win_id;
      if (!win_id) begin
        gnt0_cnt_d = (&gnt0_cnt_q) ? gnt0_cnt_q : gnt0_cnt_q + 1'b1;
      end else begin
        gnt1_cnt_d = (&gnt1_cnt_q) ? gnt1_cnt_q : gnt1_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      gnt0_cnt_q <= gnt0_cnt_d;
      gnt1_cnt_q <= gnt1_cnt_d;
    end
  end

  assign sa_if.rsp_valid = (state_q == ST_FULL);
  assign sa_if.rsp_id    = rsp_id_q;
  assign sa_if.rsp_data  = rsp_data_q;
  assign sa_if.rsp_err   = rsp_err_q;
  assign sa_if.gnt0_cnt  = gnt0_cnt_q;
  assign sa_if.gnt1_cnt  = gnt1_cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  shift_arbiter_if #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) bus ();
  shift_arbiter_if #(.DATA_W(32), .SHAMT_W(5), .CNT_W(2))  sbus ();

  shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .sa_if (bus)
  );

  shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst   (rst),
    .sa_if (sbus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one slot holding the outstanding result.
  bit          m_full;
  bit          m_id;
  logic [31:0] m_data;
  bit          m_err;
  bit          m_pref;
  int          m_cnt0, m_cnt1;
  bit          e_rdy0, e_rdy1;

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
    case (op)
      2'b00:   return a >> s;
      2'b01:   return a << s;
      2'b10:   return $signed(a) >>> s;
      default: return a;
    endcase
  endfunction

  task automatic model_reset();
    m_full = 0; m_id = 0; m_data = '0; m_err = 0; m_pref = 0;
    m_cnt0 = 0; m_cnt1 = 0; e_rdy0 = 0; e_rdy1 = 0;
  endtask

  // Called just after a rising edge with inputs already driven; returns just after the next one.
  task automatic cycle();
    bit v0, v1, can, w, rr;
    logic [1:0] op; logic [31:0] a; logic [4:0] s;
    @(negedge clk);
    v0  = bus.req0_valid;
    v1  = bus.req1_valid;
    rr  = bus.rsp_ready;
    can = !m_full || rr;
    w   = (v0 && v1) ? m_pref : v1;
    e_rdy0 = can && v0 && !w;
    e_rdy1 = can && v1 && w;
    check("req0_ready", bus.req0_ready, e_rdy0);
    check("req1_ready", bus.req1_ready, e_rdy1);
    check("rsp_valid", bus.rsp_valid, m_full);
    if (m_full) begin
      check("rsp_id", bus.rsp_id, m_id);
      check("rsp_data", bus.rsp_data, m_data);
      check("rsp_err", bus.rsp_err, m_err);
    end
    check("gnt0_cnt", bus.gnt0_cnt, m_cnt0);
    check("gnt1_cnt", bus.gnt1_cnt, m_cnt1);
    op = w ? bus.req1_op : bus.req0_op;
    a  = w ? bus.req1_a : bus.req0_a;
    s  = w ? bus.req1_shamt : bus.req0_shamt;
    @(posedge clk);
    if (e_rdy0 || e_rdy1) begin
      m_full = 1; m_id = w; m_data = ref_shift(op, a, s); m_err = (op == 2'b11);
      if (v0 && v1) m_pref = !w;
      if (!w) m_cnt0 = (m_cnt0 == 65535) ? m_cnt0 : m_cnt0 + 1;
      else    m_cnt1 = (m_cnt1 == 65535) ? m_cnt1 : m_cnt1 + 1;
    end else if (rr) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic set_req(input int r, input bit v, input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_shamt = s;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_shamt = s;
    end
  endtask

  function automatic logic [31:0] rand_a();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000 | $urandom;
      1:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Requesters keep payload until accepted, then maybe present a fresh one.
  task automatic refill(input int pct);
    if (!bus.req0_valid || e_rdy0)
      set_req(0, $urandom_range(0, 99) < pct, 2'($urandom), rand_a(), 5'($urandom));
    if (!bus.req1_valid || e_rdy1)
      set_req(1, $urandom_range(0, 99) < pct, 2'($urandom), rand_a(), 5'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [31:0] held_data;
  logic        held_id;

  initial begin
    model_reset();
    set_req(0, 0, 2'b00, '0, '0);
    set_req(1, 0, 2'b00, '0, '0);
    bus.rsp_ready = 1'b0;
    sbus.req0_valid = 0; sbus.req0_op = 2'b00; sbus.req0_a = '0; sbus.req0_shamt = '0;
    sbus.req1_valid = 0; sbus.req1_op = 2'b00; sbus.req1_a = '0; sbus.req1_shamt = '0;
    sbus.rsp_ready = 1'b0;

    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b1;
    #1;
    check("rst_rdy0", bus.req0_ready, 0);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_data", bus.rsp_data, 0);
    check("rst_id", bus.rsp_id, 0);
    check("rst_err", bus.rsp_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Test 1: reset while FULL and stalled, then a first op
    set_req(0, 1, 2'b01, 32'h5, 3);
    cycle();
    set_req(0, 0, 2'b00, '0, '0);
    check("t1_full", bus.rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_valid", bus.rsp_valid, 0);
    check("t1_rst_cnt0", bus.gnt0_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    set_req(0, 1, 2'b01, 32'h1, 4);
    cycle();
    set_req(0, 0, 2'b00, '0, '0);
    bus.rsp_ready = 1'b1;
    check("t1_data", bus.rsp_data, 32'h10);
    check("t1_id", bus.rsp_id, 0);
    cycle();

    // Test 2: operation types
    set_req(1, 1, 2'b10, 32'h8000_0000, 31);
    cycle();
    check("t2_sra", bus.rsp_data, 32'hFFFF_FFFF);
    set_req(1, 1, 2'b00, 32'h8000_0000, 31);
    cycle();
    check("t2_srl", bus.rsp_data, 32'h0000_0001);
    set_req(1, 1, 2'b11, 32'h1234, 7);
    cycle();
    check("t2_ill_data", bus.rsp_data, 32'h1234);
    check("t2_ill_err", bus.rsp_err, 1);
    set_req(1, 1, 2'b01, 32'hABCD, 0);
    cycle();
    check("t2_shamt0", bus.rsp_data, 32'hABCD);
    check("t2_err0", bus.rsp_err, 0);
    set_req(1, 0, 2'b00, '0, '0);
    cycle();

    // Test 3: contention alternates starting with req0
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      refill(100);
      cycle();
      check("t3_id", bus.rsp_id, i % 2);
    end
    check("t3_cnt0", bus.gnt0_cnt, 2);
    check("t3_cnt1", bus.gnt1_cnt, 2);

    // Test 4: stall holds the response and blocks both requesters
    bus.rsp_ready = 1'b0;
    held_data = bus.rsp_data;
    held_id   = bus.rsp_id;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_data_hold", bus.rsp_data, held_data);
      check("t4_id_hold", bus.rsp_id, held_id);
    end
    set_req(0, 0, 2'b00, '0, '0);
    set_req(1, 1, 2'b10, 32'hF000_0000, 4);
    bus.rsp_ready = 1'b1;
    cycle();
    check("t4_nobubble", bus.rsp_valid, 1);
    check("t4_data", bus.rsp_data, 32'hFF00_0000);
    check("t4_id", bus.rsp_id, 1);
    set_req(1, 0, 2'b00, '0, '0);
    cycle();

    // Test 5: back-to-back stream from req0
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1, 2'b01, 32'(i * 3 + 1), 1);
      cycle();
      check("t5_valid", bus.rsp_valid, 1);
      check("t5_data", bus.rsp_data, 32'((i * 3 + 1) * 2));
      check("t5_id", bus.rsp_id, 0);
    end
    set_req(0, 0, 2'b00, '0, '0);
    cycle();

    // Random traffic with backpressure
    do_reset();
    for (int i = 0; i < 400; i++) begin
      refill(70);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Test 6: counter saturation on a narrow instance
    set_req(0, 0, 2'b00, '0, '0);
    set_req(1, 0, 2'b00, '0, '0);
    do_reset();
    sbus.req1_valid = 1'b1;
    sbus.req1_a = 32'h40;
    sbus.req1_shamt = 2;
    sbus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_cnt1_2", sbus.gnt1_cnt, 2);
    repeat (3) @(posedge clk);
    #1;
    check("t6_cnt1_sat", sbus.gnt1_cnt, 3);
    check("t6_cnt0", sbus.gnt0_cnt, 0);
    check("t6_data", sbus.rsp_data, 32'h10);
    sbus.req1_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
